sargantana_itag_ctrl: RTL and testbench
=======================================

// Module: sargantana_itag_ctrl
// PURPOSE
//  Requester side of the I-cache tag SRAM: drives req/we/vbit/flush/addr/data into the tag memory and consumes its
//  registered tag_way/vbit outputs. Turns fetch lookups into one-cycle-later hit/way responses. Sequences refills as
//  read-set, pick-victim, write-tag. Issues flushes. Sits between the fetch stage and the tag memory.
// PARAMETERS
//  ICACHE_N_WAY    4                    number of ways
//  TAG_DEPTH       64                   sets per way
//  TAG_ADDR_WIDHT  $clog2(TAG_DEPTH)    set index width
//  TAG_WIDHT       20                   tag width
// PORTS
//  clk_i             in   1               clock (single clock domain)
//  rst_i             in   1               asynchronous reset, active-high
//  flush_i           in   1               invalidate all lines (pulse)
//  lookup_valid_i    in   1               lookup request
//  lookup_ready_o    out  1               lookup accepted when valid&ready
//  lookup_idx_i      in   TAG_ADDR_WIDHT  set index
//  lookup_tag_i      in   TAG_WIDHT       tag to compare
//  resp_valid_o      out  1               lookup result valid (1-cycle pulse)
//  resp_hit_o        out  1               any way matched
//  resp_way_o        out  ICACHE_N_WAY    one-hot hit way
//  resp_multihit_o   out  1               more than one way matched (error)
//  refill_valid_i    in   1               install tag request
//  refill_ready_o    out  1               refill accepted when valid&ready
//  refill_idx_i      in   TAG_ADDR_WIDHT  set index to install
//  refill_tag_i      in   TAG_WIDHT       tag to install
//  refill_done_o     out  1               pulse: tag written
//  refill_way_o      out  ICACHE_N_WAY    one-hot victim way, valid with refill_done_o
//  tag_req_o         out  ICACHE_N_WAY    per-way request to tag memory
//  tag_we_o          out  1               write enable to tag memory
//  tag_vbit_o        out  1               valid bit written
//  tag_flush_o       out  1               flush to tag memory
//  tag_data_o        out  TAG_WIDHT       tag to write
//  tag_addr_o        out  TAG_ADDR_WIDHT  set index
//  tag_way_i         in   N_WAY*TAG_WIDHT tags read, one cycle after the request
//  tag_vbit_i        in   ICACHE_N_WAY    valid bits read, one cycle after the request
// BEHAVIOUR
//  - Reset: state=IDLE and rr_ptr=0. All outputs are 0 except lookup_ready_o=1 and refill_ready_o=1.
//  - FSM states: IDLE, CMP, RF_RD, RF_WR. Request priority is flush > refill > lookup.
//  - Lookup (IDLE or CMP, no refill or flush pending): lookup_ready_o=1.
//    On accept: tag_req_o='1, tag_we_o=0, tag_addr_o=lookup_idx_i; the tag is latched; next state is CMP.
//  - CMP: resp_valid_o=1. way[k] = tag_vbit_i[k] & (tag_way_i[k]==latched tag).
//    resp_hit_o=|way and resp_multihit_o=$countones(way)>1.
//    A new lookup may be accepted in CMP the same cycle, giving one lookup per cycle.
//  - Refill accept (IDLE/CMP): tag_req_o='1, read of refill_idx_i issued, next state RF_RD.
//    lookup_ready_o and refill_ready_o stay 0 until refill_done_o.
//  - RF_RD, victim choice: lowest-index way with tag_vbit_i=0; if all ways are valid, way rr_ptr is chosen
//    and rr_ptr increments (wraps N_WAY-1 -> 0). The victim is registered; next state RF_WR.
//  - RF_WR: tag_req_o=victim, tag_we_o=1, tag_vbit_o=1, tag_data_o=refill tag, tag_addr_o=refill idx.
//    refill_done_o=1 with refill_way_o=victim; next state IDLE. Latency is accept to done = 2 cycles.
//  - flush_i: tag_flush_o=1 the same cycle (combinational from flush_i). Next state IDLE and rr_ptr=0.
//    resp_valid_o is forced to 0 in that cycle; an in-flight refill is dropped with no refill_done_o.
//    Requests presented in a flush cycle are not accepted (ready=0).
//  - Simultaneous refill and lookup: the refill wins and the lookup waits.
//  - Asynchronous reset asserted mid-refill: returns to IDLE with no write issued.
//  - When no request is active, tag_req_o=0.
// STRUCTURE
//  - Package sargantana_icache_pkg holds the itag_state_t enum {IDLE,CMP,RF_RD,RF_WR} and the way-mask typedef.
//  - Sub-module sargantana_icache_victim_sel is combinational: vbit vector + rr_ptr -> one-hot victim + all_valid.
// TESTING
//  1. Reset, then lookup idx=5 tag=0x12345 on a cold cache -> CMP cycle with resp_valid_o=1, resp_hit_o=0.
//  2. Refill idx=5 tag=0x12345 -> refill_done_o 2 cycles later with refill_way_o=0001.
//     A following lookup -> resp_hit_o=1, resp_way_o=0001.
//  3. Fill all 4 ways of idx=7, then two more refills -> victims are way 0, then way 1 (rr_ptr).
//  4. Back-to-back lookups idx=1,2,3 on consecutive cycles -> three consecutive resp_valid_o with correct hits.
//  5. flush_i during RF_RD -> tag_flush_o=1 and no refill_done_o. A subsequent lookup of any set -> miss.
//  6. Assert rst_i during RF_WR setup -> all outputs return to reset values and tag_we_o stays 0.

Source files
------------

// File: rtl/sargantana_icache_pkg.sv
// Shared types for the I-cache tag controller slice.
// Way masks are one-hot or multi-hot vectors, one bit per way.
package sargantana_icache_pkg;

  localparam int ICACHE_N_WAY   = 4;
  localparam int TAG_DEPTH      = 64;
  localparam int TAG_ADDR_WIDHT = $clog2(TAG_DEPTH);
  localparam int TAG_WIDHT      = 20;
  localparam int RR_WIDHT       = $clog2(ICACHE_N_WAY);

  typedef logic [ICACHE_N_WAY-1:0]   way_mask_t;
  typedef logic [RR_WIDHT-1:0]       rr_ptr_t;
  typedef logic [TAG_ADDR_WIDHT-1:0] tag_idx_t;
  typedef logic [TAG_WIDHT-1:0]      tag_t;

  typedef enum logic [1:0] {
    IDLE,
    CMP,
    RF_RD,
    RF_WR
  } itag_state_t;

endpackage

// File: rtl/sargantana_itag_ctrl_if.sv
// Fetch-side lookup/refill/flush requests and the
// tag-memory port of the I-cache tag controller.
interface sargantana_itag_ctrl_if;
  import sargantana_icache_pkg::*;

  logic      flush_i;
  logic      lookup_valid_i;
  logic      lookup_ready_o;
  tag_idx_t  lookup_idx_i;
  tag_t      lookup_tag_i;
  logic      resp_valid_o;
  logic      resp_hit_o;
  way_mask_t resp_way_o;
  logic      resp_multihit_o;
  logic      refill_valid_i;
  logic      refill_ready_o;
  tag_idx_t  refill_idx_i;
  tag_t      refill_tag_i;
  logic      refill_done_o;
  way_mask_t refill_way_o;
  way_mask_t tag_req_o;
  logic      tag_we_o;
  logic      tag_vbit_o;
  logic      tag_flush_o;
  tag_t      tag_data_o;
  tag_idx_t  tag_addr_o;
  logic [ICACHE_N_WAY*TAG_WIDHT-1:0] tag_way_i;
  way_mask_t tag_vbit_i;

  modport slave (
    input  flush_i, lookup_valid_i,
    input  lookup_idx_i, lookup_tag_i,
    input  refill_valid_i, refill_idx_i,
    input  refill_tag_i, tag_way_i, tag_vbit_i,
    output lookup_ready_o, resp_valid_o,
    output resp_hit_o, resp_way_o,
    output resp_multihit_o, refill_ready_o,
    output refill_done_o, refill_way_o,
    output tag_req_o, tag_we_o, tag_vbit_o,
    output tag_flush_o, tag_data_o, tag_addr_o
  );

  modport master (
    output flush_i, lookup_valid_i,
    output lookup_idx_i, lookup_tag_i,
    output refill_valid_i, refill_idx_i,
    output refill_tag_i, tag_way_i, tag_vbit_i,
    input  lookup_ready_o, resp_valid_o,
    input  resp_hit_o, resp_way_o,
    input  resp_multihit_o, refill_ready_o,
    input  refill_done_o, refill_way_o,
    input  tag_req_o, tag_we_o, tag_vbit_o,
    input  tag_flush_o, tag_data_o, tag_addr_o
  );

endinterface

// File: rtl/sargantana_icache_victim_sel.sv
// Refill victim choice: first invalid way, else the
// round-robin way when the whole set is valid.
module sargantana_icache_victim_sel
  import sargantana_icache_pkg::*;
(
  input  way_mask_t vbit,
  input  rr_ptr_t   rr_ptr,
  output way_mask_t victim,
  output logic      all_valid
);

  // scan high to low so the lowest free way wins
  always_comb begin
    victim    = '0;
    all_valid = &vbit;
    if (all_valid) begin
      victim[rr_ptr] = 1'b1;
    end else begin
      for (int k = ICACHE_N_WAY-1; k >= 0; k--) begin
        if (!vbit[k]) begin
          victim    = '0;
          victim[k] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/sargantana_itag_ctrl.sv
// Requester side of the I-cache tag SRAM: lookups,
// read-pick-write refills and flushes.
module sargantana_itag_ctrl
  import sargantana_icache_pkg::*;
(
  input logic clk_i,
  input logic rst_i,
  sargantana_itag_ctrl_if.slave bus
);

  itag_state_t state_q, state_d;
  rr_ptr_t     rr_q;
  tag_t        lk_tag_q;
  tag_idx_t    rf_idx_q;
  tag_t        rf_tag_q;
  way_mask_t   victim_q;
  way_mask_t   victim_w;
  logic        all_valid_w;
  way_mask_t   hit_way;
  logic        idle_cmp;
  logic        rf_rdy;
  logic        lk_rdy;
  logic        rf_acc;
  logic        lk_acc;
  logic        cmp_act;
  logic        wr_act;

  assign idle_cmp = (state_q == IDLE) ||
                    (state_q == CMP);
  assign rf_rdy = idle_cmp & ~bus.flush_i;
  assign lk_rdy = rf_rdy & ~bus.refill_valid_i;
  assign rf_acc = rf_rdy & bus.refill_valid_i;
  assign lk_acc = lk_rdy & bus.lookup_valid_i;
  assign cmp_act = (state_q == CMP) & ~bus.flush_i;
  assign wr_act = (state_q == RF_WR) & ~bus.flush_i;

  sargantana_icache_victim_sel u_victim (
    .vbit      (bus.tag_vbit_i),
    .rr_ptr    (rr_q),
    .victim    (victim_w),
    .all_valid (all_valid_w)
  );

  // per-way tag match against the latched lookup tag
  always_comb begin
    hit_way = '0;
    for (int k = 0; k < ICACHE_N_WAY; k++) begin
      hit_way[k] = bus.tag_vbit_i[k] &
        (bus.tag_way_i[k*TAG_WIDHT +: TAG_WIDHT]
         == lk_tag_q);
    end
  end

  // state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // next state: flush > refill > lookup
  always_comb begin
    state_d = state_q;
    if (bus.flush_i) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE, CMP: begin
          if (rf_acc)      state_d = RF_RD;
          else if (lk_acc) state_d = CMP;
          else             state_d = IDLE;
        end
        RF_RD: state_d = RF_WR;
        RF_WR: state_d = IDLE;
      endcase
    end
  end

  // outputs to fetch and to the tag memory
  always_comb begin
    bus.lookup_ready_o  = lk_rdy;
    bus.refill_ready_o  = rf_rdy;
    bus.tag_flush_o     = bus.flush_i;
    bus.resp_valid_o    = cmp_act;
    bus.resp_hit_o      = cmp_act & (|hit_way);
    bus.resp_way_o      = cmp_act ? hit_way : '0;
    bus.resp_multihit_o = cmp_act &
      (|(hit_way & (hit_way - 1'b1)));
    bus.refill_done_o   = 1'b0;
    bus.refill_way_o    = '0;
    bus.tag_req_o       = '0;
    bus.tag_we_o        = 1'b0;
    bus.tag_vbit_o      = 1'b0;
    bus.tag_data_o      = '0;
    bus.tag_addr_o      = '0;
    unique case (1'b1)
      rf_acc: begin
        bus.tag_req_o  = '1;
        bus.tag_addr_o = bus.refill_idx_i;
      end
      lk_acc: begin
        bus.tag_req_o  = '1;
        bus.tag_addr_o = bus.lookup_idx_i;
      end
      wr_act: begin
        bus.tag_req_o     = victim_q;
        bus.tag_we_o      = 1'b1;
        bus.tag_vbit_o    = 1'b1;
        bus.tag_data_o    = rf_tag_q;
        bus.tag_addr_o    = rf_idx_q;
        bus.refill_done_o = 1'b1;
        bus.refill_way_o  = victim_q;
      end
      default: ;
    endcase
  end

  // request latches, victim register, round-robin pointer
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_q     <= '0;
      lk_tag_q <= '0;
      rf_idx_q <= '0;
      rf_tag_q <= '0;
      victim_q <= '0;
    end else if (bus.flush_i) begin
      rr_q <= '0;
    end else begin
      if (lk_acc) lk_tag_q <= bus.lookup_tag_i;
      if (rf_acc) begin
        rf_idx_q <= bus.refill_idx_i;
        rf_tag_q <= bus.refill_tag_i;
      end
      if (state_q == RF_RD) begin
        victim_q <= victim_w;
        if (all_valid_w) begin
          rr_q <= (rr_q == rr_ptr_t'(ICACHE_N_WAY-1))
                  ? '0 : rr_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sargantana_itag_ctrl.sv
// Bench for sargantana_itag_ctrl: tag SRAM model,
// request-level cache model and directed scenarios.
module tb_sargantana_itag_ctrl;
  import sargantana_icache_pkg::*;

  localparam int NW = ICACHE_N_WAY;
  localparam int TW = TAG_WIDHT;
  localparam int ND = TAG_DEPTH;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   chk_cnt = 0;
  int   pass_cnt = 0;

  sargantana_itag_ctrl_if bus_if();

  sargantana_itag_ctrl dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t",
                  name, act, exp, $time);
  endtask

  // tag SRAM: registered reads, writes, global flush
  bit [TW-1:0] mem_t [NW][ND];
  bit          mem_v [NW][ND];

  always @(posedge clk) begin
    if (bus_if.tag_flush_o) begin
      for (int k = 0; k < NW; k++)
        for (int s = 0; s < ND; s++) mem_v[k][s] <= 1'b0;
    end else begin
      for (int k = 0; k < NW; k++) begin
        if (bus_if.tag_req_o[k]) begin
          if (bus_if.tag_we_o) begin
            mem_t[k][bus_if.tag_addr_o] <= bus_if.tag_data_o;
            mem_v[k][bus_if.tag_addr_o] <= bus_if.tag_vbit_o;
          end else begin
            bus_if.tag_way_i[k*TW +: TW] <=
              mem_t[k][bus_if.tag_addr_o];
            bus_if.tag_vbit_i[k] <= mem_v[k][bus_if.tag_addr_o];
          end
        end
      end
    end
  end

  // request-level model: cache contents per set, a refill
  // countdown, one pending lookup result
  bit          m_v [ND][NW];
  bit [TW-1:0] m_t [ND][NW];
  int          m_busy, m_rr, p_set, p_k;
  bit          m_pend;
  logic [NW-1:0] m_pway, p_way;
  logic [TW-1:0] p_tag;
  logic [NW-1:0] e_way, e_req;
  logic e_rr, e_lr, e_racc, e_lacc, e_rv, e_done;
  int   lidx, v;

  always @(negedge clk) begin
    if (rst) begin
      m_busy = 0; m_pend = 0; m_rr = 0;
      chk("rst lookup_ready", 32'(bus_if.lookup_ready_o), 1);
      chk("rst refill_ready", 32'(bus_if.refill_ready_o), 1);
      chk("rst resp_valid", 32'(bus_if.resp_valid_o), 0);
      chk("rst tag_req", 32'(bus_if.tag_req_o), 0);
      chk("rst tag_we", 32'(bus_if.tag_we_o), 0);
      chk("rst refill_done", 32'(bus_if.refill_done_o), 0);
      chk("rst tag_flush", 32'(bus_if.tag_flush_o), 0);
    end else begin
      e_rr   = !bus_if.flush_i && m_busy == 0;
      e_lr   = e_rr && !bus_if.refill_valid_i;
      e_racc = e_rr && bus_if.refill_valid_i;
      e_lacc = e_lr && bus_if.lookup_valid_i;
      e_rv   = m_pend && !bus_if.flush_i;
      e_way  = e_rv ? m_pway : '0;
      e_done = m_busy == 2 && !bus_if.flush_i;
      if (e_racc || e_lacc) e_req = '1;
      else if (e_done)      e_req = p_way;
      else                  e_req = '0;
      chk("lookup_ready", 32'(bus_if.lookup_ready_o), 32'(e_lr));
      chk("refill_ready", 32'(bus_if.refill_ready_o), 32'(e_rr));
      chk("resp_valid", 32'(bus_if.resp_valid_o), 32'(e_rv));
      chk("resp_way", 32'(bus_if.resp_way_o), 32'(e_way));
      chk("resp_hit", 32'(bus_if.resp_hit_o), 32'(e_way != 0));
      chk("resp_multihit", 32'(bus_if.resp_multihit_o),
          32'($countones(e_way) > 1));
      chk("refill_done", 32'(bus_if.refill_done_o), 32'(e_done));
      chk("refill_way", 32'(bus_if.refill_way_o),
          32'(e_done ? p_way : '0));
      chk("tag_req", 32'(bus_if.tag_req_o), 32'(e_req));
      chk("tag_we", 32'(bus_if.tag_we_o), 32'(e_done));
      chk("tag_flush", 32'(bus_if.tag_flush_o),
          32'(bus_if.flush_i));
      m_pend = 0;
      if (bus_if.flush_i) begin
        for (int s = 0; s < ND; s++)
          for (int k = 0; k < NW; k++) m_v[s][k] = 0;
        m_rr = 0; m_busy = 0;
      end else if (m_busy == 2) begin
        m_t[p_set][p_k] = p_tag;
        m_v[p_set][p_k] = 1;
        m_busy = 0;
      end else if (m_busy == 1) begin
        m_busy = 2;
      end else if (e_racc) begin
        p_set = int'(bus_if.refill_idx_i);
        p_tag = bus_if.refill_tag_i;
        v = -1;
        for (int k = 0; k < NW; k++)
          if (v < 0 && !m_v[p_set][k]) v = k;
        if (v < 0) begin
          v = m_rr;
          m_rr = (m_rr + 1) % NW;
        end
        p_k = v;
        p_way = '0;
        p_way[v] = 1'b1;
        m_busy = 1;
      end else if (e_lacc) begin
        lidx = int'(bus_if.lookup_idx_i);
        m_pend = 1;
        for (int k = 0; k < NW; k++)
          m_pway[k] = m_v[lidx][k] &&
                      m_t[lidx][k] == bus_if.lookup_tag_i;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_lookup(input int idx, input int tag,
                           input logic eh,
                           input logic [NW-1:0] ew,
                           input logic em);
    bus_if.lookup_valid_i = 1'b1;
    bus_if.lookup_idx_i   = tag_idx_t'(idx);
    bus_if.lookup_tag_i   = tag_t'(tag);
    tick();
    bus_if.lookup_valid_i = 1'b0;
    chk("lk resp_valid", 32'(bus_if.resp_valid_o), 1);
    chk("lk resp_hit", 32'(bus_if.resp_hit_o), 32'(eh));
    chk("lk resp_way", 32'(bus_if.resp_way_o), 32'(ew));
    chk("lk multihit", 32'(bus_if.resp_multihit_o), 32'(em));
    tick();
  endtask

  task automatic do_refill(input int idx, input int tag,
                           input logic [NW-1:0] ew);
    bus_if.refill_valid_i = 1'b1;
    bus_if.refill_idx_i   = tag_idx_t'(idx);
    bus_if.refill_tag_i   = tag_t'(tag);
    tick();
    bus_if.refill_valid_i = 1'b0;
    chk("rf early done", 32'(bus_if.refill_done_o), 0);
    tick();
    chk("rf done", 32'(bus_if.refill_done_o), 1);
    chk("rf way", 32'(bus_if.refill_way_o), 32'(ew));
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bus_if.flush_i        = 1'b0;
    bus_if.lookup_valid_i = 1'b0;
    bus_if.lookup_idx_i   = '0;
    bus_if.lookup_tag_i   = '0;
    bus_if.refill_valid_i = 1'b0;
    bus_if.refill_idx_i   = '0;
    bus_if.refill_tag_i   = '0;
    tick();
    chk("reset ready", 32'(bus_if.lookup_ready_o), 1);
    chk("reset req", 32'(bus_if.tag_req_o), 0);
    tick();
    rst = 1'b0;
    tick();

    do_lookup(5, 'h12345, 1'b0, 4'b0000, 1'b0);
    do_refill(5, 'h12345, 4'b0001);
    do_lookup(5, 'h12345, 1'b1, 4'b0001, 1'b0);

    for (int i = 0; i < 4; i++)
      do_refill(7, 'h70 + i, 4'(1 << i));
    do_refill(7, 'h74, 4'b0001);
    do_refill(7, 'h75, 4'b0010);
    do_lookup(7, 'h74, 1'b1, 4'b0001, 1'b0);
    do_lookup(7, 'h72, 1'b1, 4'b0100, 1'b0);
    do_lookup(7, 'h70, 1'b0, 4'b0000, 1'b0);

    do_refill(9, 'haa, 4'b0001);
    do_refill(9, 'haa, 4'b0010);
    do_lookup(9, 'haa, 1'b1, 4'b0011, 1'b1);

    do_refill(1, 'h111, 4'b0001);
    do_refill(3, 'h333, 4'b0001);
    bus_if.lookup_valid_i = 1'b1;
    bus_if.lookup_idx_i   = 6'd1;
    bus_if.lookup_tag_i   = 20'h111;
    tick();
    bus_if.lookup_idx_i = 6'd2;
    bus_if.lookup_tag_i = 20'h222;
    chk("b2b 1 hit", 32'(bus_if.resp_way_o), 32'h1);
    tick();
    bus_if.lookup_idx_i = 6'd3;
    bus_if.lookup_tag_i = 20'h333;
    chk("b2b 2 valid", 32'(bus_if.resp_valid_o), 1);
    chk("b2b 2 miss", 32'(bus_if.resp_hit_o), 0);
    tick();
    bus_if.lookup_valid_i = 1'b0;
    chk("b2b 3 hit", 32'(bus_if.resp_way_o), 32'h1);
    tick();

    bus_if.lookup_valid_i = 1'b1;
    bus_if.lookup_idx_i   = 6'd12;
    bus_if.lookup_tag_i   = 20'hccc;
    bus_if.refill_valid_i = 1'b1;
    bus_if.refill_idx_i   = 6'd12;
    bus_if.refill_tag_i   = 20'hccc;
    #1;
    chk("both lk_ready", 32'(bus_if.lookup_ready_o), 0);
    chk("both rf_ready", 32'(bus_if.refill_ready_o), 1);
    tick();
    bus_if.refill_valid_i = 1'b0;
    chk("rd lk_ready", 32'(bus_if.lookup_ready_o), 0);
    tick();
    chk("wr done", 32'(bus_if.refill_done_o), 1);
    chk("wr lk_ready", 32'(bus_if.lookup_ready_o), 0);
    tick();
    chk("idle lk_ready", 32'(bus_if.lookup_ready_o), 1);
    tick();
    bus_if.lookup_valid_i = 1'b0;
    chk("waited hit", 32'(bus_if.resp_way_o), 32'h1);
    tick();

    bus_if.refill_valid_i = 1'b1;
    bus_if.refill_idx_i   = 6'd10;
    bus_if.refill_tag_i   = 20'hddd;
    tick();
    bus_if.refill_valid_i = 1'b0;
    bus_if.flush_i        = 1'b1;
    #1;
    chk("fl tag_flush", 32'(bus_if.tag_flush_o), 1);
    chk("fl rf_ready", 32'(bus_if.refill_ready_o), 0);
    tick();
    bus_if.flush_i = 1'b0;
    chk("fl no done 1", 32'(bus_if.refill_done_o), 0);
    tick();
    chk("fl no done 2", 32'(bus_if.refill_done_o), 0);
    do_lookup(5, 'h12345, 1'b0, 4'b0000, 1'b0);
    do_lookup(10, 'hddd, 1'b0, 4'b0000, 1'b0);
    do_lookup(7, 'h74, 1'b0, 4'b0000, 1'b0);
    for (int i = 0; i < 4; i++)
      do_refill(7, 'h80 + i, 4'(1 << i));
    do_refill(7, 'h84, 4'b0001);

    bus_if.refill_valid_i = 1'b1;
    bus_if.refill_idx_i   = 6'd11;
    bus_if.refill_tag_i   = 20'heee;
    tick();
    bus_if.refill_valid_i = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst mid we", 32'(bus_if.tag_we_o), 0);
    chk("rst mid done", 32'(bus_if.refill_done_o), 0);
    chk("rst mid ready", 32'(bus_if.refill_ready_o), 1);
    tick();
    chk("rst hold we", 32'(bus_if.tag_we_o), 0);
    rst = 1'b0;
    tick();
    chk("post rst we", 32'(bus_if.tag_we_o), 0);
    do_lookup(11, 'heee, 1'b0, 4'b0000, 1'b0);
    tick();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
